// File: rtl/onehot_seq_tx_if.sv
// Load port and serial-line bundle for the one-hot run detector transmitter.
// master: the transmitter side. slave: the producer/observer side.
interface onehot_seq_tx_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] data_in;
    logic             load_valid;
    logic             load_ready;
    logic             w;
    logic             w_valid;
    logic             frame_done;
    logic [2:0]       state;
    logic             z_exp;

    modport master (
        input  data_in,
        input  load_valid,
        output load_ready,
        output w,
        output w_valid,
        output frame_done,
        output state,
        output z_exp
    );

    modport slave (
        output data_in,
        output load_valid,
        input  load_ready,
        input  w,
        input  w_valid,
        input  frame_done,
        input  state,
        input  z_exp
    );
endinterface

// File: rtl/onehot_seq_tx.sv
// Serial transmitter for the one-hot run detector. A word loaded in IDLE is sent
// MSB-first on w, followed by an idle gap. z_exp is a cycle-exact copy of the
// detector's z output (last two sampled w bits equal).
module onehot_seq_tx #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned GAP_CYCLES = 2,
    parameter logic        IDLE_LEVEL = 1'b0
) (
    input logic             clk,
    input logic             rst,
    onehot_seq_tx_if.master tx_io
);

    typedef enum logic [2:0] {
        StIdle  = 3'b001,
        StShift = 3'b010,
        StGap   = 3'b100
    } state_e;

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned GapW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    localparam logic [CntW-1:0] BitLoad = CntW'(WIDTH - 1);
    // Only used when GAP_CYCLES > 0; clamped so the constant stays legal otherwise.
    localparam logic [GapW-1:0] GapLoad = GapW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_e           state_q;
    logic [WIDTH-1:0] shreg_q;
    logic [CntW-1:0]  bitcnt_q;
    logic [GapW-1:0]  gapcnt_q;

    logic             h1_q;
    logic             h2_q;
    logic [1:0]       fill_q;

    logic             w;
    logic             w_valid;
    logic             frame_done;
    logic             load_ready;
    logic             z_exp;

    // Frame sequencer: IDLE accepts a word, SHIFT sends WIDTH bits, GAP pads the line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            gapcnt_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (tx_io.load_valid) begin
                        shreg_q  <= tx_io.data_in;
                        bitcnt_q <= BitLoad;
                        state_q  <= StShift;
                    end
                end
                StShift: begin
                    shreg_q  <= {shreg_q[WIDTH-2:0], 1'b0};
                    bitcnt_q <= bitcnt_q - CntW'(1);
                    if (bitcnt_q == '0) begin
                        if (GAP_CYCLES == 0) begin
                            state_q <= StIdle;
                        end else begin
                            gapcnt_q <= GapLoad;
                            state_q  <= StGap;
                        end
                    end
                end
                StGap: begin
                    gapcnt_q <= gapcnt_q - GapW'(1);
                    if (gapcnt_q == '0) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Line and handshake outputs, decoded from registered state only.
    always_comb begin
        load_ready = (state_q == StIdle);
        w_valid    = (state_q == StShift);
        w          = w_valid ? shreg_q[WIDTH-1] : IDLE_LEVEL;
        frame_done = w_valid && (bitcnt_q == '0);
        z_exp      = (fill_q == 2'd2) && (h1_q == h2_q);
    end

    // Detector model: shift the sampled w into a two-deep history, saturating fill at 2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h1_q   <= 1'b0;
            h2_q   <= 1'b0;
            fill_q <= 2'd0;
        end else begin
            h2_q   <= h1_q;
            h1_q   <= w;
            fill_q <= (fill_q == 2'd2) ? 2'd2 : fill_q + 2'd1;
        end
    end

    assign tx_io.load_ready = load_ready;
    assign tx_io.w          = w;
    assign tx_io.w_valid    = w_valid;
    assign tx_io.frame_done = frame_done;
    assign tx_io.state      = state_q;
    assign tx_io.z_exp      = z_exp;

    // The state register must never leave the one-hot set.
    a_state_onehot: assert property (@(posedge clk) disable iff (rst) $onehot(state_q));

endmodule

// File: doc/onehot_seq_tx.md
Name: onehot_seq_tx

Overview:
- Serial bit-stream transmitter that drives the single-bit `w` line consumed by the team's one-hot run detector (z=1 when the last two sampled w bits are equal).
- Accepts a parallel word through a valid/ready load port and shifts it out MSB-first, one bit per clock.
- Inserts a programmable idle gap between frames.
- Produces `z_exp`, a cycle-exact model of the detector's z output, so benches and on-chip checkers can compare against the receiver directly.

Parameters:
- WIDTH, 8, bits per frame (≥2).
- GAP_CYCLES, 2, minimum GAP-state cycles after each frame (0 allowed).
- IDLE_LEVEL, 1'b0, value driven on w when no frame is being shifted.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- data_in  in  WIDTH  frame word; sampled only on the accept edge.
- load_valid  in  1  producer has a word on data_in.
- load_ready  out  1  transmitter can accept a word (high only in IDLE).
- w  out  1  serial output bit to the detector.
- w_valid  out  1  high while w carries a frame bit (SHIFT state).
- frame_done  out  1  high during the cycle the last (LSB) frame bit is on w.
- state  out  3  one-hot state: [0]=IDLE, [1]=SHIFT, [2]=GAP.
- z_exp  out  1  expected detector z for the current cycle.

Behaviour:
- Reset is asynchronous and active-high. On assertion, regardless of state:
  - state=3'b001, shift register=0, bit counter=0, gap counter=0.
  - History bits h1/h2=0, history fill=0.
  - Outputs: w=IDLE_LEVEL, w_valid=0, frame_done=0, z_exp=0, load_ready=1.
  - A frame in progress is aborted: no frame_done, no remaining bits.
- Exactly one state bit is high at all times. No other encoding is reachable.
- IDLE:
  - load_ready=1, w=IDLE_LEVEL, w_valid=0.
  - Accept edge = rising edge with IDLE & load_valid: shreg<=data_in, bitcnt<=WIDTH-1, state<=SHIFT.
- SHIFT:
  - w=shreg[WIDTH-1] (combinational from register), w_valid=1, load_ready=0.
  - Every edge: shreg shifts left by 1, bitcnt decrements.
  - frame_done = SHIFT & (bitcnt==0).
  - Edge with bitcnt==0: go to GAP with gapcnt<=GAP_CYCLES-1, or to IDLE directly if GAP_CYCLES==0.
  - Exactly WIDTH SHIFT cycles per frame; the MSB appears in the cycle right after the accept edge.
- GAP:
  - w=IDLE_LEVEL, w_valid=0, load_ready=0.
  - gapcnt decrements each edge; edge with gapcnt==0 → IDLE.
  - Minimum spacing between frames is therefore GAP_CYCLES+1 cycles of IDLE_LEVEL (the GAP cycles plus one IDLE accept cycle).
- load_valid and data_in are ignored outside IDLE. Changes to data_in during SHIFT/GAP must not affect the bits being sent.
- z_exp model (tracks w every cycle, in every state, including idle and gap):
  - Each edge: h2<=h1, h1<=w, fill<=min(fill+1, 2).
  - z_exp = (fill==2) & (h1==h2), taken from registers only.
  - This matches the detector: z reflects the previous two sampled bits, and is 0 for the first two cycles after reset.
- Counter widths: $clog2(WIDTH) and $clog2(GAP_CYCLES+1), with a minimum of 1 bit each. No wrap-around is possible because counters reload on each state entry.

Test Plan:
- Reset check (WIDTH=8, GAP=2, IDLE_LEVEL=0): assert Reset → state=001, w=0, w_valid=0, load_ready=1, frame_done=0, z_exp=0. Release and wait 2 edges → z_exp=1 (two idle 0s sampled).
- Single frame: load 0xB4 with a one-cycle load_valid pulse →
  - w over the next 8 cycles = 1,0,1,1,0,1,0,0 with w_valid=1;
  - frame_done only in the 8th cycle;
  - then 2 GAP cycles (state=100, load_ready=0), then IDLE (load_ready=1).
- z_exp tracking: after ≥2 idle cycles, load 0xFF →
  - z_exp=0 in the cycle after the first 1 is sampled (history 0,1);
  - z_exp=1 from the next cycle through one cycle past the last bit;
  - z_exp=0 when the 1→0 transition enters history.
- Back-to-back: hold load_valid=1 with words 0xA5 then 0x3C → exactly 3 IDLE_LEVEL cycles between the last bit of 0xA5 and the MSB of 0x3C, and both frames are bit-exact.
- Ignored loads: toggle load_valid and change data_in every cycle during SHIFT and GAP → transmitted bits and state sequence are unchanged; only one accept happens per IDLE visit.
- Mid-frame reset: assert Reset after 3 bits of 0xF0 →
  - state=001, w=0, z_exp=0 immediately (asynchronously);
  - no frame_done;
  - after release, loading 0x81 transmits all 8 bits correctly.
